pipeline_hazard_ctrl: RTL

Issue controller for the mips_16 IF/ID front end. It keeps an 8-entry write-back scoreboard of in-flight destination registers and stalls decode on read-after-write hazards. It also generates the branch-squash pulse for IF and sequences a debug halt/drain. It drives instruction_decode_en into the ID stage and the matching fetch enable into the IF stage.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 29 ++
 rtl/pipeline_hazard_ctrl_reg_scoreboard.sv | 72 +++++++
 rtl/pipeline_hazard_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and constants for the IF/ID issue controller
//
// Purpose: FSM state encoding, default write-back latency and counter width,
//          scoreboard geometry and a helper that sizes the per-register counters.
// Ports:   none (package).
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        PHC_RUN    = 2'd0,
        PHC_DRAIN  = 2'd1,
        PHC_HALTED = 2'd2
    } phc_state_e;

    localparam int PHC_WB_LATENCY_DEF = 3;
    localparam int PHC_CNT_W_DEF      = 16;
    localparam int PHC_NUM_REGS       = 8;
    localparam int PHC_REG_AW         = 3;

    // Bits needed to hold the values 0..lat; at least one bit.
    function automatic int phc_cnt_width(input int lat);
        int w;
        w = 1;
        while ((1 << w) < (lat + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_reg_scoreboard.sv
// rtl/pipeline_hazard_ctrl_reg_scoreboard.sv - write-back scoreboard of in-flight destination registers
//
// Purpose: one down-counter per architectural register R1..R7. A producer that
//          issues loads WB_LATENCY into its destination counter; every counter
//          that is nonzero decrements on each edge. R0 is never busy.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   load, load_addr          issue edge of a register-writing instruction and its destination
//   rd_addr1, rd_addr2       source registers of the instruction in ID
//   busy                     bit r set while the counter of register r is nonzero
//   hazard1, hazard2         source register 1 / 2 is still in flight
module reg_scoreboard
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int WB_LATENCY = PHC_WB_LATENCY_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [PHC_REG_AW-1:0]   load_addr,
    input  logic [PHC_REG_AW-1:0]   rd_addr1,
    input  logic [PHC_REG_AW-1:0]   rd_addr2,
    output logic [PHC_NUM_REGS-1:0] busy,
    output logic                    hazard1,
    output logic                    hazard2
);

    localparam int            CW       = phc_cnt_width(WB_LATENCY);
    localparam logic [CW-1:0] LOAD_VAL = CW'(WB_LATENCY);

    logic [CW-1:0] cnt_q [1:PHC_NUM_REGS-1];
    logic [CW-1:0] cnt_d [1:PHC_NUM_REGS-1];

    // Load takes priority over the free-running decrement.
    always_comb begin
        cnt_d = cnt_q;
        for (int r = 1; r < PHC_NUM_REGS; r++) begin
            if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
            if (load && (load_addr == PHC_REG_AW'(r))) begin
                cnt_d[r] = LOAD_VAL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 1; r < PHC_NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < PHC_NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 1; r < PHC_NUM_REGS; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    // busy[0] is constant 0, so a zero source never raises a hazard.
    // Reads use the pre-edge counts, so an instruction that reads and
    // writes the same register only waits on an older producer.
    assign hazard1 = busy[rd_addr1];
    assign hazard2 = busy[rd_addr2];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - IF/ID issue controller: RAW stalls, branch squash, debug halt/drain
//
// Purpose: stalls decode while a source register is still in flight, squashes
//          the wrong-path fetch on a taken branch, and sequences a debug halt
//          that waits for the scoreboard to drain.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   decoding_op_src1/src2            ID source registers (0 = none)
//   id_op_writes_reg, id_dest        ID instruction writes back, and where
//   id_branch_taken                  branch condition true for the ID instruction
//   ext_stall_req                    instruction memory not ready
//   halt_req                         debug halt request (level)
//   instruction_fetch_en             IF may advance
//   instruction_decode_en            ID issues this edge (0 = bubble, hold IR)
//   pipeline_flush                   IF substitutes a NOP at this edge
//   halted                           pipeline drained and frozen
//   sb_busy                          per-register scoreboard busy bits
//   stall_count                      saturating count of hazard-stall cycles
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int WB_LATENCY = PHC_WB_LATENCY_DEF,
    parameter int CNT_W      = PHC_CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PHC_REG_AW-1:0]   decoding_op_src1,
    input  logic [PHC_REG_AW-1:0]   decoding_op_src2,
    input  logic                    id_op_writes_reg,
    input  logic [PHC_REG_AW-1:0]   id_dest,
    input  logic                    id_branch_taken,
    input  logic                    ext_stall_req,
    input  logic                    halt_req,
    output logic                    instruction_fetch_en,
    output logic                    instruction_decode_en,
    output logic                    pipeline_flush,
    output logic                    halted,
    output logic [PHC_NUM_REGS-1:0] sb_busy,
    output logic [CNT_W-1:0]        stall_count
);

    phc_state_e       state_q, state_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic hazard1, hazard2, hazard;
    logic issue, sb_load, stall_inc;

    reg_scoreboard #(
        .WB_LATENCY (WB_LATENCY)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .load      (sb_load),
        .load_addr (id_dest),
        .rd_addr1  (decoding_op_src1),
        .rd_addr2  (decoding_op_src2),
        .busy      (sb_busy),
        .hazard1   (hazard1),
        .hazard2   (hazard2)
    );

    assign hazard = hazard1 | hazard2;

    // rst is folded in so the enables and flush are 0 while reset is held,
    // independent of whatever the ID inputs are doing.
    assign issue = rst && (state_q == PHC_RUN) && !hazard && !ext_stall_req && !halt_req;

    assign instruction_decode_en = issue;
    assign instruction_fetch_en  = issue;
    // Combinational so the wrong-path instruction is replaced in the same edge.
    assign pipeline_flush        = issue && id_branch_taken;

    assign sb_load = issue && id_op_writes_reg && (id_dest != '0);

    // A cycle lost to a memory wait is not counted as a hazard stall.
    assign stall_inc = (state_q == PHC_RUN) && hazard && !ext_stall_req;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PHC_RUN: begin
                if (halt_req) begin
                    state_d = PHC_DRAIN;
                end
            end
            PHC_DRAIN: begin
                // A dropped request wins over a drain that completes on the same edge.
                if (!halt_req) begin
                    state_d = PHC_RUN;
                end else if (sb_busy == '0) begin
                    state_d = PHC_HALTED;
                end
            end
            PHC_HALTED: begin
                if (!halt_req) begin
                    state_d = PHC_RUN;
                end
            end
            default: state_d = PHC_RUN;
        endcase
        halted_d = (state_d == PHC_HALTED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= PHC_RUN;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign halted      = halted_q;
    assign stall_count = stall_cnt_q;

endmodule
